// File: rtl/gb_oam_dma.sv
// gb_oam_dma -- OAM DMA controller behind I/O register FF46.
//
// A CPU write to FF46 latches the source page. It then copies 160 bytes from
// {page, 00..9F} into OAM bytes 00..9F. Each byte takes BYTE_CYCLES clocks:
// phase 0 reads the source and phase 1 writes OAM. The remaining phases are idle.
//
// Ports
//   clk      gbclk; all state changes on its rising edge
//   n_reset  asynchronous active-low reset
//   sel      CPU access targets FF46
//   write    CPU write strobe
//   din      CPU write data
//   dout     FF46 readback (source register)
//   active   transfer in progress, including the start delay
//   adr_rd   source read address
//   rd       source read strobe (one cycle per byte)
//   mem_in   source read data, valid while rd is high
//   adr_wr   OAM byte index 00..9F
//   wr       OAM write strobe (one cycle per byte)
//   mem_out  OAM write data
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no transfer; strobes low
// S_START | start delay after an FF46 write, delay counts 0..START_DELAY-1
// S_XFER  | copying byte idx, phase counts 0..BYTE_CYCLES-1

module gb_oam_dma #(
  parameter int START_DELAY = 4,
  parameter int BYTE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        sel,
  input  logic        write,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic        active,
  output logic [15:0] adr_rd,
  output logic        rd,
  input  logic [7:0]  mem_in,
  output logic [7:0]  adr_wr,
  output logic        wr,
  output logic [7:0]  mem_out
);

  localparam int DW = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
  localparam int PW = $clog2(BYTE_CYCLES);
  localparam logic [DW-1:0] DELAY_LAST = DW'(START_DELAY - 1);
  localparam logic [PW-1:0] PHASE_LAST = PW'(BYTE_CYCLES - 1);
  localparam logic [7:0]    IDX_LAST   = 8'd159;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_XFER
  } state_t;

  state_t        state;
  logic [7:0]    src;
  logic [7:0]    idx;
  logic [7:0]    page;
  logic [DW-1:0] delay;
  logic [PW-1:0] phase;

  // Pages E0..FF fold down onto the C0..DF echo. As a result, FE/FF never
  // read back OAM or I/O space.
  assign page = (src < 8'hE0) ? src : (src - 8'h20);
  assign dout = src;

  // Outputs are registered. Each strobe is set on the edge that enters its
  // phase, so rd is high during phase 0 and wr is high during phase 1.
  // mem_out doubles as the byte buffer: it is loaded with mem_in at the end
  // of phase 0.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state   <= S_IDLE;
      src     <= 8'hFF;
      idx     <= 8'h00;
      delay   <= '0;
      phase   <= '0;
      active  <= 1'b0;
      rd      <= 1'b0;
      wr      <= 1'b0;
      adr_rd  <= 16'h0000;
      adr_wr  <= 8'h00;
      mem_out <= 8'h00;
    end else begin
      rd <= 1'b0;
      wr <= 1'b0;
      if (sel && write) begin
        // A restart takes priority over everything. This drops the byte in
        // flight and any pending phase-1 write.
        src    <= din;
        state  <= S_START;
        active <= 1'b1;
        idx    <= 8'h00;
        delay  <= '0;
        phase  <= '0;
      end else begin
        case (state)
          S_START: begin
            if (delay == DELAY_LAST) begin
              state  <= S_XFER;
              idx    <= 8'h00;
              phase  <= '0;
              rd     <= 1'b1;
              adr_rd <= {page, 8'h00};
            end else begin
              delay <= delay + 1'b1;
            end
          end
          S_XFER: begin
            if (phase == '0) begin
              mem_out <= mem_in;
              wr      <= 1'b1;
              adr_wr  <= idx;
            end
            if (phase == PHASE_LAST) begin
              if (idx == IDX_LAST) begin
                state  <= S_IDLE;
                active <= 1'b0;
              end else begin
                idx    <= idx + 8'd1;
                phase  <= '0;
                rd     <= 1'b1;
                adr_rd <= {page, idx + 8'd1};
              end
            end else begin
              phase <= phase + 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule
